// File: rtl/ddr3_rd_pkg.sv
// Shared types and helpers for the DDR read-data assembly path.
// Optional feature macro: RD_PARITY_EN (used by the files importing this package).
package ddr3_rd_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_CL, CAPTURE} rd_state_t;

   localparam int FIFO_DEPTH = 2;

   // Widest burst the parity helper accepts; callers zero-extend into it.
   localparam int PARITY_MAX_W = 4096;

   // Even parity of a burst (zero-extension does not change the result).
   function automatic logic burst_parity(input logic [PARITY_MAX_W-1:0] burst);
      return ^burst;
   endfunction

endpackage

// File: rtl/rd_burst_fifo.sv
// Two-entry burst FIFO with 1-bit wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
// head reads as zero whenever the FIFO is empty.
module rd_burst_fifo
   import ddr3_rd_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   logic [W-1:0] mem_reg [FIFO_DEPTH];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;

   assign full    = (count_reg == 2'(FIFO_DEPTH));
   assign empty   = (count_reg == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         // Write the entry addressed by the write pointer on an accepted push.
         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               mem_reg[gi] <= '0;
            else if (do_push && (wr_ptr_reg == 1'(gi)))
               mem_reg[gi] <= din;
         end
      end
   endgenerate

   // Pointer and occupancy bookkeeping; pop and push may coincide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/read_data_assembler.sv
// Gathers BL/2 capture words into one burst, CL cycles after a read command,
// and queues completed bursts in a 2-entry FIFO toward the controller core.
// Optional feature macro: RD_PARITY_EN adds a per-entry parity bit and the rd_parity port.
module read_data_assembler
   import ddr3_rd_pkg::*;
#(
   parameter int BW = 8,
   parameter int BL = 8,
   parameter int CL = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            rd_start,
   input  logic [2*BW-1:0] word_in,
   output logic [BW*BL-1:0] rd_data,
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic            busy,
   output logic            cmd_err,
`ifdef RD_PARITY_EN
   output logic            rd_parity,
`endif
   output logic            overflow
);

   localparam int WORDS   = BL / 2;
   localparam int BEAT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WORD_W  = 2 * BW;
   localparam int BURST_W = BW * BL;
`ifdef RD_PARITY_EN
   localparam int ENTRY_W = BURST_W + 1;
`else
   localparam int ENTRY_W = BURST_W;
`endif

   rd_state_t          state_reg, state_next;
   logic [3:0]         lat_reg, lat_next;
   logic [BEAT_W-1:0]  beat_reg, beat_next;
   logic [BURST_W-1:0] asm_reg, asm_next;
   logic               cmd_err_reg;
   logic               overflow_reg;
   logic               capture_en;
   logic               last_word;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_head;

   assign last_word = (beat_reg == BEAT_W'(WORDS - 1));
   assign push      = capture_en && last_word;
   assign pop       = !fifo_empty && rd_ready;

   // Next-state logic; the edge where the latency counter is zero captures word 0.
   always_comb begin
      state_next = state_reg;
      lat_next   = lat_reg;
      beat_next  = beat_reg;
      capture_en = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rd_start) begin
               state_next = WAIT_CL;
               lat_next   = 4'(CL - 1);
            end
         end
         WAIT_CL: begin
            if (lat_reg == 4'd0) begin
               capture_en = 1'b1;
               state_next = CAPTURE;
            end else begin
               lat_next = lat_reg - 4'd1;
            end
         end
         CAPTURE: capture_en = 1'b1;
         default: state_next = IDLE;
      endcase
      if (capture_en) begin
         if (last_word) begin
            state_next = IDLE;
            beat_next  = '0;
         end else begin
            beat_next = beat_reg + 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_slot
         assign asm_next[gi*WORD_W +: WORD_W] =
            (capture_en && (beat_reg == BEAT_W'(gi))) ? word_in : asm_reg[gi*WORD_W +: WORD_W];
      end
   endgenerate

   // FSM, counters and assembly register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         lat_reg   <= 4'd0;
         beat_reg  <= '0;
         asm_reg   <= '0;
      end else begin
         state_reg <= state_next;
         lat_reg   <= lat_next;
         beat_reg  <= beat_next;
         asm_reg   <= asm_next;
      end
   end

   // Status flags: one-cycle command error pulse and sticky overflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_err_reg  <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         cmd_err_reg  <= rd_start && (state_reg != IDLE);
         overflow_reg <= overflow_reg | (push && fifo_full && !pop);
      end
   end

`ifdef RD_PARITY_EN
   assign fifo_din  = {burst_parity(PARITY_MAX_W'(asm_next)), asm_next};
   assign rd_parity = fifo_head[BURST_W];
`else
   assign fifo_din  = asm_next;
`endif

   rd_burst_fifo #(
      .W (ENTRY_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign rd_data  = fifo_head[BURST_W-1:0];
   assign rd_valid = !fifo_empty;
   assign busy     = (state_reg != IDLE);
   assign cmd_err  = cmd_err_reg;
   assign overflow = overflow_reg;

endmodule
